// File: rtl/seq_multiplier_pkg.sv
// Shared FSM type and elaboration/datapath helpers for the sequential multiplier.
package seq_multiplier_pkg;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    // Widest operand that mag() can take a magnitude of.
    localparam int MAG_W = 64;
    localparam int IDX_W = $clog2(MAG_W);

    function automatic int ceil_div(input int num, input int den);
        return (num + den - 1) / den;
    endfunction

    // Unsigned magnitude of the low w bits of value. The most negative
    // w-bit value maps to 2^(w-1), which still fits in w unsigned bits.
    function automatic logic [MAG_W-1:0] mag(input logic [MAG_W-1:0] value,
                                             input int w,
                                             input logic is_signed);
        logic [MAG_W-1:0] mask;
        mask = {MAG_W{1'b1}} >> (MAG_W - w);
        if (is_signed && value[IDX_W'(w - 1)])
            return (~value + MAG_W'(1)) & mask;
        return value & mask;
    endfunction

endpackage

// File: rtl/seq_multiplier_digit_pp.sv
// Combinational partial product of the multiplicand magnitude and one digit of b.
module mult_digit_pp
    import seq_multiplier_pkg::*;
#(
    parameter int WIDTH_A    = 32,
    parameter int DIGIT_BITS = 1
) (
    input  logic [WIDTH_A-1:0]            a_mag,
    input  logic [DIGIT_BITS-1:0]         digit,
    output logic [WIDTH_A+DIGIT_BITS-1:0] pp
);

    localparam int PP_W = WIDTH_A + DIGIT_BITS;

    always_comb begin
        pp = '0;
        for (int k = 0; k < DIGIT_BITS; k++) begin
            if (digit[k])
                pp = pp + (PP_W'(a_mag) << k);
        end
    end

endmodule

// File: rtl/seq_multiplier.sv
// Multi-cycle radix-2^DIGIT_BITS shift-add multiplier with valid/ready on both sides.
module seq_multiplier
    import seq_multiplier_pkg::*;
#(
    parameter int WIDTH_A    = 32,
    parameter int WIDTH_B    = 32,
    parameter int DIGIT_BITS = 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [WIDTH_A-1:0]         a,
    input  logic [WIDTH_B-1:0]         b,
    input  logic                       is_signed,
    input  logic                       in_valid,
    output logic                       in_ready,
    output logic [WIDTH_A+WIDTH_B-1:0] product,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic                       busy
);

    localparam int N     = ceil_div(WIDTH_B, DIGIT_BITS);
    localparam int BP_W  = N * DIGIT_BITS;
    localparam int ACC_W = WIDTH_A + BP_W;
    localparam int PP_W  = WIDTH_A + DIGIT_BITS;
    localparam int P_W   = WIDTH_A + WIDTH_B;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

    state_t              state;
    state_t              state_next;
    logic                accept;
    logic                last_step;
    logic [WIDTH_A-1:0]  a_mag;
    logic [BP_W-1:0]     b_rem;
    logic                neg;
    logic [ACC_W-1:0]    acc;
    logic [ACC_W-1:0]    acc_next;
    logic [ACC_W+DIGIT_BITS-1:0] acc_sum;
    logic [PP_W-1:0]     pp;
    logic [P_W-1:0]      prod_mag;
    logic [CNT_W-1:0]    cnt;

    mult_digit_pp #(
        .WIDTH_A   (WIDTH_A),
        .DIGIT_BITS(DIGIT_BITS)
    ) u_pp (
        .a_mag(a_mag),
        .digit(b_rem[DIGIT_BITS-1:0]),
        .pp   (pp)
    );

    assign accept    = in_valid && in_ready;
    assign last_step = (cnt == CNT_W'(N - 1));
    assign out_valid = (state == DONE);

    // Shift-right accumulation: the digit's partial product lands just above
    // the b-width window, then the whole value drops by one digit.
    assign acc_sum  = {DIGIT_BITS'(0), acc} + {pp, BP_W'(0)};
    assign acc_next = ACC_W'(acc_sum >> DIGIT_BITS);
    assign prod_mag = P_W'(acc_next);

    always_ff @(posedge clk) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        busy       = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid)
                    state_next = CALC;
            end
            CALC: begin
                busy = 1'b1;
                if (last_step)
                    state_next = DONE;
            end
            DONE: begin
                // Ready opens in the same cycle the result is taken, so a
                // waiting operand pair starts with no bubble.
                if (out_ready) begin
                    in_ready   = 1'b1;
                    state_next = in_valid ? CALC : IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt     <= '0;
            product <= '0;
        end else begin
            if (accept)
                cnt <= '0;
            else if (state == CALC)
                cnt <= cnt + CNT_W'(1);
            if (state == CALC && last_step)
                product <= neg ? -prod_mag : prod_mag;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            a_mag <= WIDTH_A'(mag(MAG_W'(a), WIDTH_A, is_signed));
            b_rem <= BP_W'(mag(MAG_W'(b), WIDTH_B, is_signed));
            neg   <= is_signed && (a[WIDTH_A-1] ^ b[WIDTH_B-1]);
            acc   <= '0;
        end else if (state == CALC) begin
            acc   <= acc_next;
            b_rem <= b_rem >> DIGIT_BITS;
        end
    end

endmodule

// File: tb/tb_seq_multiplier.sv
// Scoreboard bench for seq_multiplier in 8x8/radix-2, 16x12/radix-16 and 16x12/radix-32 builds.
module tb_seq_multiplier;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // 8x8, one bit per cycle
    logic [7:0]  a8, b8;
    logic        s8, iv8, ir8, ov8, or8, busy8;
    logic [15:0] p8;
    logic [15:0] q8[$];
    int          acc_cyc8 = 0;
    logic        ov8_q = 1'b0;

    // 16x12 builds: index 0 = 4-bit digits, index 1 = 5-bit digits
    logic [1:0][15:0] a16;
    logic [1:0][11:0] b16;
    logic [1:0]       s16, iv16, ir16, ov16, or16, busy16;
    logic [1:0][27:0] p16;
    logic [27:0]      q16_0[$];
    logic [27:0]      q16_1[$];
    int               acc_cyc16[2];
    logic [1:0]       ov16_q = 2'b00;

    seq_multiplier #(.WIDTH_A(8), .WIDTH_B(8), .DIGIT_BITS(1)) u_m8 (
        .clk(clk), .rst_n(rst_n), .a(a8), .b(b8), .is_signed(s8),
        .in_valid(iv8), .in_ready(ir8), .product(p8), .out_valid(ov8),
        .out_ready(or8), .busy(busy8));

    seq_multiplier #(.WIDTH_A(16), .WIDTH_B(12), .DIGIT_BITS(4)) u_d4 (
        .clk(clk), .rst_n(rst_n), .a(a16[0]), .b(b16[0]), .is_signed(s16[0]),
        .in_valid(iv16[0]), .in_ready(ir16[0]), .product(p16[0]), .out_valid(ov16[0]),
        .out_ready(or16[0]), .busy(busy16[0]));

    seq_multiplier #(.WIDTH_A(16), .WIDTH_B(12), .DIGIT_BITS(5)) u_d5 (
        .clk(clk), .rst_n(rst_n), .a(a16[1]), .b(b16[1]), .is_signed(s16[1]),
        .in_valid(iv16[1]), .in_ready(ir16[1]), .product(p16[1]), .out_valid(ov16[1]),
        .out_ready(or16[1]), .busy(busy16[1]));

    function automatic logic [15:0] model8(input logic [7:0] a, input logic [7:0] b, input logic s);
        logic signed [15:0] ps;
        if (s) begin
            ps = $signed(a) * $signed(b);
            return ps;
        end
        return 16'(a) * 16'(b);
    endfunction

    function automatic logic [27:0] model16(input logic [15:0] a, input logic [11:0] b, input logic s);
        logic signed [27:0] ps;
        if (s) begin
            ps = $signed(a) * $signed(b);
            return ps;
        end
        return 28'(a) * 28'(b);
    endfunction

    // Output monitors: compare every handshake against the queue head.
    always @(negedge clk) begin
        logic [15:0] e8;
        if (rst_n) begin
            if (ov8 && !ov8_q)
                check("lat8", 64'(cyc - acc_cyc8), 64'd8);
            if (ov8 && or8) begin
                if (q8.size() == 0)
                    check("q8_unexpected", 64'(q8.size()), 64'd1);
                else begin
                    e8 = q8.pop_front();
                    check("res8", 64'(p8), 64'(e8));
                end
            end
        end
        ov8_q = ov8;
    end

    always @(negedge clk) begin
        logic [27:0] e16;
        for (int i = 0; i < 2; i++) begin
            if (rst_n) begin
                if (ov16[i] && !ov16_q[i])
                    check(i == 0 ? "lat_d4" : "lat_d5", 64'(cyc - acc_cyc16[i]), 64'd3);
                if (ov16[i] && or16[i]) begin
                    if ((i == 0 ? q16_0.size() : q16_1.size()) == 0)
                        check("q16_unexpected", 64'(i), 64'd9);
                    else begin
                        e16 = (i == 0) ? q16_0.pop_front() : q16_1.pop_front();
                        check(i == 0 ? "res_d4" : "res_d5", 64'(p16[i]), 64'(e16));
                    end
                end
            end
            ov16_q[i] = ov16[i];
        end
    end

    // Called just after a posedge; returns just after the accept edge.
    task automatic send8(input logic [7:0] a, input logic [7:0] b, input logic s);
        logic got;
        a8 = a; b8 = b; s8 = s; iv8 = 1'b1;
        q8.push_back(model8(a, b, s));
        got = 1'b0;
        for (int t = 0; t < 100 && !got; t++) begin
            @(negedge clk);
            got = ir8;
        end
        if (!got) check("send8_ready", 64'(ir8), 64'd1);
        @(posedge clk); #1;
        acc_cyc8 = cyc;
        iv8 = 1'b0;
    endtask

    task automatic send16(input int i, input logic [15:0] a, input logic [11:0] b, input logic s);
        logic got;
        a16[i] = a; b16[i] = b; s16[i] = s; iv16[i] = 1'b1;
        if (i == 0) q16_0.push_back(model16(a, b, s));
        else        q16_1.push_back(model16(a, b, s));
        got = 1'b0;
        for (int t = 0; t < 100 && !got; t++) begin
            @(negedge clk);
            got = ir16[i];
        end
        if (!got) check("send16_ready", 64'(ir16[i]), 64'd1);
        @(posedge clk); #1;
        acc_cyc16[i] = cyc;
        iv16[i] = 1'b0;
    endtask

    // Returns at the negedge where out_valid is seen.
    task automatic wait_ov8();
        logic got = 1'b0;
        for (int t = 0; t < 100 && !got; t++) begin
            @(negedge clk);
            got = ov8;
        end
        check("ov8_seen", 64'(ov8), 64'd1);
    endtask

    task automatic wait_ov16(input int i);
        logic got = 1'b0;
        for (int t = 0; t < 100 && !got; t++) begin
            @(negedge clk);
            got = ov16[i];
        end
        check("ov16_seen", 64'(ov16[i]), 64'd1);
    endtask

    task automatic drain();
        for (int t = 0; t < 200 && (q8.size() + q16_0.size() + q16_1.size()) != 0; t++)
            @(negedge clk);
        check("drained", 64'(q8.size() + q16_0.size() + q16_1.size()), 64'd0);
    endtask

    initial begin
        logic [27:0] e28;
        logic [15:0] dropped;
        rst_n = 1'b0;
        a8 = '0; b8 = '0; s8 = 1'b0; iv8 = 1'b0; or8 = 1'b1;
        a16 = '0; b16 = '0; s16 = '0; iv16 = '0; or16 = 2'b11;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("rst_ov", 64'(ov8), 64'd0);
        check("rst_busy", 64'(busy8), 64'd0);
        check("rst_prod", 64'(p8), 64'd0);
        check("rst_ready", 64'(ir8), 64'd1);
        check("rst_p16", 64'(p16), 64'd0);
        check("rst_ready16", 64'(ir16), 64'd3);

        // Unsigned 200 x 150 with a one-cycle result pulse
        @(posedge clk); #1;
        send8(8'd200, 8'd150, 1'b0);
        wait_ov8();
        check("u_200x150", 64'(p8), 64'd30000);
        @(negedge clk);
        check("pulse_1cyc", 64'(ov8), 64'd0);

        // Signed corners and unsigned MSB-set operands
        @(posedge clk); #1;
        send8(8'h80, 8'h80, 1'b1);
        wait_ov8();
        check("s_mneg_sq", 64'(p8), 64'h4000);
        @(posedge clk); #1;
        send8(8'hFF, 8'd127, 1'b1);
        wait_ov8();
        check("s_m1x127", 64'(p8), 64'hFF81);
        @(posedge clk); #1;
        send8(8'h80, 8'h80, 1'b0);
        wait_ov8();
        check("u_80x80", 64'(p8), 64'h4000);

        // Back-to-back random stream, zeros included
        @(posedge clk); #1;
        send8(8'd0, 8'd255, 1'b1);
        send8(8'd255, 8'd255, 1'b0);
        for (int k = 0; k < 6; k++)
            send8(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)));
        drain();

        // Backpressure: hold for 10 cycles, ignore a stray in_valid pulse
        @(posedge clk); #1;
        or8 = 1'b0;
        send8(8'd77, 8'd3, 1'b0);
        wait_ov8();
        for (int k = 0; k < 10; k++) begin
            check("bp_ov", 64'(ov8), 64'd1);
            check("bp_prod", 64'(p8), 64'd231);
            check("bp_ready", 64'(ir8), 64'd0);
            @(posedge clk); #1;
            if (k == 3) begin a8 = 8'd5; b8 = 8'd5; s8 = 1'b0; iv8 = 1'b1; end
            if (k == 4) iv8 = 1'b0;
            @(negedge clk);
        end
        @(posedge clk); #1;
        or8 = 1'b1;
        a8 = 8'hFD; b8 = 8'd100; s8 = 1'b1; iv8 = 1'b1;
        q8.push_back(model8(8'hFD, 8'd100, 1'b1));
        @(negedge clk);
        check("ho_ready", 64'(ir8), 64'd1);
        @(posedge clk); #1;
        acc_cyc8 = cyc;
        iv8 = 1'b0;
        check("ho_busy", 64'(busy8), 64'd1);
        check("ho_ov", 64'(ov8), 64'd0);
        wait_ov8();
        check("ho_prod", 64'(p8), 64'hFED4);
        drain();

        // Reset at the 4th CALC step aborts the transaction
        @(posedge clk); #1;
        send8(8'd99, 8'd99, 1'b0);
        repeat (3) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        dropped = q8.pop_back();
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("abort_ov", 64'(ov8), 64'd0);
        check("abort_busy", 64'(busy8), 64'd0);
        check("abort_prod", 64'(p8), 64'd0);
        check("abort_ready", 64'(ir8), 64'd1);
        send8(8'd11, 8'd13, 1'b0);
        wait_ov8();
        check("after_abort", 64'(p8), 64'd143);
        drain();

        // 16x12 builds: 4-bit digits and padded 5-bit digits
        @(posedge clk); #1;
        send16(0, 16'hFC18, 12'd2047, 1'b1);
        wait_ov16(0);
        e28 = 28'(-2047000);
        check("d4_signed", 64'(p16[0]), 64'(e28));
        @(posedge clk); #1;
        send16(1, 16'hFFFF, 12'hFFF, 1'b0);
        wait_ov16(1);
        check("d5_unsigned_max", 64'(p16[1]), 64'hFFEF001);
        @(posedge clk); #1;
        send16(1, 16'h8000, 12'h800, 1'b1);
        wait_ov16(1);
        check("d5_mneg", 64'(p16[1]), 64'h4000000);
        @(posedge clk); #1;
        for (int k = 0; k < 4; k++) begin
            send16(0, 16'($urandom), 12'($urandom), 1'($urandom_range(0, 1)));
            send16(1, 16'($urandom), 12'($urandom), 1'($urandom_range(0, 1)));
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
